// File: rtl/box_plotter.sv
// box_plotter: rectangle-fill engine for the VGA drawing path.
// Latches a base coordinate, box size and colour on start, then emits one
// pixel per cycle in raster order (x fastest) with a registered plot strobe.
// Optional build macro BOX_CLIP_EN: suppresses plot for pixels outside the
// SCREEN_W x SCREEN_H visible area or whose coordinate sum overflows.
module box_plotter #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int DIM_W    = 4,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                pause,
    input  logic [X_W-1:0]      x_in,
    input  logic [Y_W-1:0]      y_in,
    input  logic [DIM_W-1:0]    w_in,
    input  logic [DIM_W-1:0]    h_in,
    input  logic [COLOUR_W-1:0] colour_in,
    output logic                ready,
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                plot,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t state, state_nxt;

    logic [X_W-1:0]      xb;
    logic [Y_W-1:0]      yb;
    logic [DIM_W-1:0]    wb;
    logic [DIM_W-1:0]    hb;
    logic [COLOUR_W-1:0] col;
    logic [DIM_W-1:0]    dx;
    logic [DIM_W-1:0]    dy;

    logic latch_en;
    logic pix_en;
    logic dx_last;
    logic last_pix;
    logic in_view;

`ifdef BOX_CLIP_EN
    // One extra bit keeps the carry so an overflowing sum can be rejected.
    function automatic logic [X_W:0] sum_x(input logic [X_W-1:0] b, input logic [DIM_W-1:0] d);
        return {1'b0, b} + (X_W+1)'(d);
    endfunction

    function automatic logic [Y_W:0] sum_y(input logic [Y_W-1:0] b, input logic [DIM_W-1:0] d);
        return {1'b0, b} + (Y_W+1)'(d);
    endfunction

    logic [X_W:0] px_sum;
    logic [Y_W:0] py_sum;

    // Pixel coordinates plus visibility test against the screen bounds.
    always_comb begin
        px_sum  = sum_x(xb, dx);
        py_sum  = sum_y(yb, dy);
        in_view = !px_sum[X_W] && !py_sum[Y_W]
                  && (px_sum < (X_W+1)'(SCREEN_W))
                  && (py_sum < (Y_W+1)'(SCREEN_H));
    end
`else
    // Plain modular sums: coordinates wrap at the register width.
    function automatic logic [X_W-1:0] sum_x(input logic [X_W-1:0] b, input logic [DIM_W-1:0] d);
        return b + X_W'(d);
    endfunction

    function automatic logic [Y_W-1:0] sum_y(input logic [Y_W-1:0] b, input logic [DIM_W-1:0] d);
        return b + Y_W'(d);
    endfunction

    logic [X_W-1:0] px_sum;
    logic [Y_W-1:0] py_sum;

    // Pixel coordinates; every pixel is plotted in the unclipped build.
    always_comb begin
        px_sum  = sum_x(xb, dx);
        py_sum  = sum_y(yb, dy);
        in_view = 1'b1;
    end

    // Screen bounds only matter for clipping; tie them off here.
    logic unused_screen;
    assign unused_screen = SCREEN_W[0] ^ SCREEN_H[0];
`endif

    assign ready    = (state == IDLE);
    assign dx_last  = (dx == wb);
    assign last_pix = dx_last && (dy == hb);

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic and datapath enables.
    always_comb begin
        state_nxt = state;
        latch_en  = 1'b0;
        pix_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    latch_en  = 1'b1;
                    state_nxt = DRAW;
                end
            end
            DRAW: begin
                if (!pause) begin
                    pix_en = 1'b1;
                    if (last_pix) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Box parameters, raster counters and registered pixel outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            xb         <= '0;
            yb         <= '0;
            wb         <= '0;
            hb         <= '0;
            col        <= '0;
            dx         <= '0;
            dy         <= '0;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
            plot       <= 1'b0;
            done       <= 1'b0;
        end else begin
            plot <= 1'b0;
            done <= (state == DONE);
            if (latch_en) begin
                xb  <= x_in;
                yb  <= y_in;
                wb  <= w_in;
                hb  <= h_in;
                col <= colour_in;
                dx  <= '0;
                dy  <= '0;
            end
            if (pix_en) begin
                x_out      <= px_sum[X_W-1:0];
                y_out      <= py_sum[Y_W-1:0];
                colour_out <= col;
                plot       <= in_view;
                if (dx_last) begin
                    dx <= '0;
                    dy <= dy + 1'b1;
                end else begin
                    dx <= dx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_box_plotter.sv
// Directed testbench for box_plotter: raster order, single pixel, pause,
// ignored mid-draw start, reset abort and the screen-edge box.
module tb_box_plotter;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic       pause;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [3:0] w_in;
    logic [3:0] h_in;
    logic [2:0] colour_in;
    logic       ready;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot;
    logic       done;

    int checks = 0;
    int errors = 0;

    box_plotter dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .pause      (pause),
        .x_in       (x_in),
        .y_in       (y_in),
        .w_in       (w_in),
        .h_in       (h_in),
        .colour_in  (colour_in),
        .ready      (ready),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot       (plot),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic exp_plot(input int x, input int y);
`ifdef BOX_CLIP_EN
        return (x < 160) && (y < 120);
`else
        return 1'b1;
`endif
    endfunction

    // Start a box and check every cycle through done and back to ready.
    task automatic run_box(input int xb, input int yb, input int w, input int h, input int c,
                           input int pause_at, input int pause_len, input int mid_start_at);
        int total;
        int ex;
        int ey;
        x_in      = 8'(xb);
        y_in      = 7'(yb);
        w_in      = 4'(w);
        h_in      = 4'(h);
        colour_in = 3'(c);
        start     = 1'b1;
        step();
        start = 1'b0;
        check("ready_after_start", 32'(ready), 0);
        check("plot_after_start", 32'(plot), 0);
        total = (w + 1) * (h + 1);
        for (int i = 0; i < total; i++) begin
            step();
            ex = (xb + i % (w + 1)) % 256;
            ey = (yb + i / (w + 1)) % 128;
            check("pix_plot", 32'(plot), 32'(exp_plot(xb + i % (w + 1), yb + i / (w + 1))));
            check("pix_x", 32'(x_out), 32'(ex));
            check("pix_y", 32'(y_out), 32'(ey));
            check("pix_colour", 32'(colour_out), 32'(c));
            check("pix_done", 32'(done), 0);
            check("pix_ready", 32'(ready), 0);
            if (i == mid_start_at) begin
                start     = 1'b1;
                x_in      = 8'd99;
                y_in      = 7'd3;
                colour_in = 3'(c ^ 1);
            end
            if (i == mid_start_at + 1) start = 1'b0;
            if (i == pause_at) begin
                pause = 1'b1;
                for (int p = 0; p < pause_len; p++) begin
                    step();
                    check("pause_plot", 32'(plot), 0);
                    check("pause_x", 32'(x_out), 32'(ex));
                    check("pause_y", 32'(y_out), 32'(ey));
                    check("pause_done", 32'(done), 0);
                end
                pause = 1'b0;
            end
        end
        step();
        check("end_plot", 32'(plot), 0);
        check("end_done", 32'(done), 1);
        step();
        check("post_done", 32'(done), 0);
        check("post_ready", 32'(ready), 1);
        check("post_plot", 32'(plot), 0);
    endtask

    initial begin
        resetn    = 1'b0;
        start     = 1'b0;
        pause     = 1'b0;
        x_in      = '0;
        y_in      = '0;
        w_in      = '0;
        h_in      = '0;
        colour_in = '0;
        step();
        step();
        check("rst_ready", 32'(ready), 1);
        check("rst_plot", 32'(plot), 0);
        check("rst_done", 32'(done), 0);
        check("rst_x", 32'(x_out), 0);
        check("rst_y", 32'(y_out), 0);
        check("rst_colour", 32'(colour_out), 0);
        resetn = 1'b1;
        step();
        check("idle_ready", 32'(ready), 1);

        // 4x4 box at (10,20), colour 5
        run_box(10, 20, 3, 3, 5, -1, 0, -1);

        // single pixel at origin, issued the cycle after ready returns
        run_box(0, 0, 0, 0, 6, -1, 0, -1);

        // 3x2 box with a 3-cycle pause after the second pixel
        run_box(40, 50, 2, 1, 3, 1, 3, -1);

        // 2x2 box with a second start during the draw
        run_box(30, 40, 1, 1, 2, -1, 0, 0);

        // reset on the fifth pixel of a 4x4 box
        x_in      = 8'd5;
        y_in      = 7'd6;
        w_in      = 4'd3;
        h_in      = 4'd3;
        colour_in = 3'd7;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("abort_pix_x", 32'(x_out), 32'(5 + i % 4));
            check("abort_pix_y", 32'(y_out), 32'(6 + i / 4));
            check("abort_pix_plot", 32'(plot), 1);
        end
        resetn = 1'b0;
        step();
        check("abort_plot", 32'(plot), 0);
        check("abort_ready", 32'(ready), 1);
        check("abort_done", 32'(done), 0);
        resetn = 1'b1;
        step();
        check("abort_done_after", 32'(done), 0);
        check("abort_plot_after", 32'(plot), 0);
        check("abort_ready_after", 32'(ready), 1);
        run_box(50, 60, 3, 3, 4, -1, 0, -1);

        // box straddling the right and bottom screen edges
        run_box(158, 118, 3, 3, 1, -1, 0, -1);

        // box wrapping past the y register width
        run_box(250, 126, 7, 3, 2, -1, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
